// File: rtl/pool_unit_arbiter.sv
// Round-robin arbiter that time-shares one accumulate-then-average pooling unit
// among NUM_REQ pool engines, one whole window per grant.
module pool_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int WIN     = 4,
    parameter int LAT     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          win_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   win_data,
    output logic [NUM_REQ-1:0]          win_ready,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [$clog2(NUM_REQ)-1:0]  owner_id,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    input  logic [NUM_REQ-1:0]          resp_ready,
    output logic                        pu_rst,
    output logic                        pu_en,
    output logic [DATA_W-1:0]           pu_din,
    input  logic [DATA_W-1:0]           pu_dout,
    output logic                        busy
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(WIN + 1);
    localparam int LAT_W  = $clog2(LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_RESET, S_FEED, S_WAIT, S_RESP} state_t;

    state_t              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     owner_q;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic [LAT_W-1:0]    lat_cnt_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  win_ready_q;
    logic [NUM_REQ-1:0]  resp_valid_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                pu_rst_q;
    logic                pu_en_q;
    logic [DATA_W-1:0]   pu_din_q;
    logic                busy_q;

    logic [ID_W-1:0]     pick_d;
    logic [NUM_REQ-1:0]  pick_oh_d;
    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [DATA_W-1:0]   owner_data;
    logic                beat_accept;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = win_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign owner_data  = data_arr[owner_q];
    assign beat_accept = (state_q == S_FEED) && win_valid[owner_q] && win_ready_q[owner_q];

    // Walk from farthest to nearest so the first set bit after the pointer wins.
    always_comb begin
        int idx;
        idx    = 0;
        pick_d = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                pick_d = ID_W'(idx);
            end
        end
        pick_oh_d = NUM_REQ'(1) << pick_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= ID_W'(NUM_REQ - 1);
            owner_q      <= '0;
            beat_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            gnt_q        <= '0;
            win_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            pu_rst_q     <= 1'b0;
            pu_en_q      <= 1'b0;
            pu_din_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            pu_rst_q <= 1'b0;
            pu_en_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        owner_q  <= pick_d;
                        gnt_q    <= pick_oh_d;
                        pu_rst_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_RESET;
                    end
                end
                S_RESET: begin
                    beat_cnt_q  <= '0;
                    win_ready_q <= gnt_q;
                    state_q     <= S_FEED;
                end
                S_FEED: begin
                    // The unit sees each accepted sample one cycle later, so the
                    // last beat's pu_en lands in the first WAIT cycle.
                    if (beat_accept) begin
                        pu_en_q  <= 1'b1;
                        pu_din_q <= owner_data;
                        if (beat_cnt_q == BEAT_W'(WIN - 1)) begin
                            win_ready_q <= '0;
                            lat_cnt_q   <= '0;
                            state_q     <= S_WAIT;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_cnt_q == LAT_W'(LAT)) begin
                        resp_data_q  <= pu_dout;
                        resp_valid_q <= gnt_q;
                        state_q      <= S_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready[owner_q]) begin
                        resp_valid_q <= '0;
                        gnt_q        <= '0;
                        ptr_q        <= owner_q;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign win_ready  = win_ready_q;
    assign gnt        = gnt_q;
    assign owner_id   = owner_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign pu_rst     = pu_rst_q;
    assign pu_en      = pu_en_q;
    assign pu_din     = pu_din_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_pool_unit_arbiter.sv
// Bench for pool_unit_arbiter: behavioural pooling unit, per-requester feeders,
// and a response scoreboard keyed by requester.
module tb_pool_unit_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int WIN     = 4;
    localparam int LAT     = 3;
    localparam int ID_W    = 2;

    typedef logic [WIN-1:0][DATA_W-1:0] win_t;
    typedef struct {
        int                        id;
        win_t                      s;
        logic signed [DATA_W-1:0]  avg;
        int                        stall;
        int                        lat;
    } vec_t;
    typedef struct {
        int                        id;
        logic signed [DATA_W-1:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [NUM_REQ-1:0]        req, win_valid, win_ready, gnt, resp_valid, resp_ready;
    logic [NUM_REQ*DATA_W-1:0] win_data;
    logic [ID_W-1:0]           owner_id;
    logic [DATA_W-1:0]         resp_data, pu_din, pu_dout;
    logic                      pu_rst, pu_en, busy;

    always #5 clk = ~clk;

    pool_unit_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .WIN(WIN), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .win_valid(win_valid), .win_data(win_data),
        .win_ready(win_ready), .gnt(gnt), .owner_id(owner_id), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_ready(resp_ready), .pu_rst(pu_rst), .pu_en(pu_en),
        .pu_din(pu_din), .pu_dout(pu_dout), .busy(busy)
    );

    // Pooling unit: accumulate, then sum>>>2 through a pipeline so pu_dout
    // is valid exactly LAT cycles after the final pu_en.
    logic signed [DATA_W-1:0] acc_q, d1_q;
    always @(posedge clk) begin
        if (pu_rst) acc_q <= '0;
        else if (pu_en) acc_q <= acc_q + $signed(pu_din);
        d1_q    <= acc_q >>> 2;
        pu_dout <= d1_q;
    end

    win_t               samp [NUM_REQ];
    int                 beat [NUM_REQ];
    logic [NUM_REQ-1:0] active = '0, vld_en = '1, rdy_en = '1;

    always_comb begin
        req        = active;
        resp_ready = rdy_en;
        win_valid  = '0;
        win_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (active[i] && beat[i] < WIN) begin
                win_valid[i] = vld_en[i];
                win_data[i*DATA_W +: DATA_W] = samp[i][beat[i]];
            end
        end
    end

    int compared = 0, mismatched = 0;
    int cyc = 0, pu_en_cnt = 0, pu_rst_cnt = 0, rv_cycle = -1;
    logic [DATA_W-1:0]  fed[$];
    int                 grant_log[$];
    exp_t               sb[$];
    logic [NUM_REQ-1:0] gnt_prev = '0;
    vec_t               tbl [6];

    function automatic win_t mk(input int a, input int b, input int c, input int d);
        win_t w;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        return w;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic check_resp(input int i);
        int k = -1;
        foreach (sb[j]) if (k < 0 && sb[j].id == i) k = j;
        if (k < 0) begin
            fail($sformatf("resp_unexpected_req%0d data=%0d", i, $signed(resp_data)));
        end else begin
            chk($sformatf("resp_data_req%0d", i), $signed(resp_data), sb[k].data);
            sb.delete(k);
        end
    endtask

    task automatic launch(input int id, input win_t s, input logic signed [DATA_W-1:0] e);
        exp_t x;
        samp[id]   = s;
        beat[id]   = 0;
        vld_en[id] = 1'b1;
        active[id] = 1'b1;
        x.id = id;
        x.data = e;
        sb.push_back(x);
    endtask

    // Observe the current cycle, then advance one clock and apply handshakes.
    task automatic step();
        logic [NUM_REQ-1:0] acc, racc;
        #1;
        acc  = win_valid & win_ready;
        racc = resp_valid & resp_ready;
        if (pu_en) begin pu_en_cnt++; fed.push_back(pu_din); end
        if (pu_rst) pu_rst_cnt++;
        if (resp_valid != 0 && rv_cycle < 0) rv_cycle = cyc;
        if (gnt != 0 && gnt_prev == 0) begin
            grant_log.push_back(int'(owner_id));
            chk("gnt_matches_owner", gnt, 1 << owner_id);
        end
        gnt_prev = gnt;
        chk("gnt_onehot0", $onehot0(gnt), 1);
        chk("ready_outside_gnt", win_ready & ~gnt, 0);
        for (int i = 0; i < NUM_REQ; i++) if (racc[i]) check_resp(i);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) beat[i]++;
            if (racc[i]) active[i] = 1'b0;
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_gnt"}, gnt, 0);
        chk({name, "_win_ready"}, win_ready, 0);
        chk({name, "_resp_valid"}, resp_valid, 0);
        chk({name, "_resp_data"}, resp_data, 0);
        chk({name, "_pu_ctl"}, {pu_rst, pu_en, busy}, 0);
        chk({name, "_pu_din"}, pu_din, 0);
        chk({name, "_owner_id"}, owner_id, 0);
    endtask

    task automatic run_window(input vec_t v);
        int c0, n, e0;
        bit stalled;
        pu_en_cnt = 0; pu_rst_cnt = 0; fed.delete(); rv_cycle = -1;
        c0 = cyc; n = 0; stalled = 0; e0 = 0;
        launch(v.id, v.s, v.avg);
        while (active[v.id] && n < 200) begin
            if (v.stall > 0 && !stalled && beat[v.id] == 2) begin
                stalled = 1;
                vld_en[v.id] = 1'b0;
                e0 = pu_en_cnt;
                repeat (v.stall) step();
                vld_en[v.id] = 1'b1;
                chk("stall_pu_en_pulses", pu_en_cnt - e0, 1);
                n += v.stall;
            end else begin
                step();
                n++;
            end
        end
        if (active[v.id]) begin
            fail($sformatf("window_timeout_req%0d", v.id));
            active[v.id] = 1'b0;
        end
        chk($sformatf("latency_req%0d", v.id), rv_cycle - c0, v.lat);
        chk("pu_rst_pulses", pu_rst_cnt, 1);
        chk("pu_en_pulses", pu_en_cnt, WIN);
        for (int b = 0; b < WIN; b++) begin
            if (fed.size() > b) chk($sformatf("pu_din_beat%0d", b), $signed(fed[b]), $signed(v.s[b]));
            else fail($sformatf("pu_din_beat%0d_missing", b));
        end
    endtask

    initial begin
        int n;
        bit relaunched;
        logic [DATA_W-1:0] held;
        int exp_rr[5];

        tbl[0] = '{id: 0, s: mk(4, 8, 12, 16),        avg: 10,  stall: 0, lat: 10};
        tbl[1] = '{id: 0, s: mk(-1, -2, -3, -4),      avg: -3,  stall: 0, lat: 10};
        tbl[2] = '{id: 1, s: mk(100, 200, 300, 400),  avg: 250, stall: 0, lat: 10};
        tbl[3] = '{id: 3, s: mk(-7, 0, 0, 0),         avg: -2,  stall: 0, lat: 10};
        tbl[4] = '{id: 2, s: mk(1, 2, 3, 5),          avg: 2,   stall: 0, lat: 10};
        tbl[5] = '{id: 0, s: mk(4, 8, 12, 16),        avg: 10,  stall: 5, lat: 15};
        for (int i = 0; i < NUM_REQ; i++) begin beat[i] = 0; samp[i] = '0; end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_window(tbl[i]);
            $display("window %0d: req%0d avg=%0d stall=%0d", i, tbl[i].id, tbl[i].avg, tbl[i].stall);
        end

        // Backpressure: response held while a competing request waits.
        grant_log.delete();
        rdy_en[0] = 1'b0;
        launch(0, mk(3, 3, 3, 3), 3);
        n = 0;
        while (!resp_valid[0] && n < 50) begin step(); n++; end
        if (!resp_valid[0]) fail("bp_resp_timeout");
        held = resp_data;
        chk("bp_resp_data", $signed(held), 3);
        launch(2, mk(40, 0, 0, 0), 10);
        for (int k = 0; k < 6; k++) begin
            chk("bp_hold_valid", resp_valid, 4'b0001);
            chk("bp_hold_data", resp_data, held);
            chk("bp_hold_gnt", gnt, 4'b0001);
            step();
        end
        rdy_en[0] = 1'b1;
        n = 0;
        while (active != 0 && n < 100) begin step(); n++; end
        if (active != 0) begin fail("bp_drain_timeout"); active = '0; end
        chk("bp_grant_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("bp_grant_first", grant_log[0], 0);
            chk("bp_grant_second", grant_log[1], 2);
        end
        $display("backpressure: req0 held 6 cycles, req2 served after");

        // Reset in WAIT aborts the window; the next window must start clean.
        launch(1, mk(1000, 2000, 3000, 4000), 2500);
        n = 0;
        while (beat[1] < WIN && n < 50) begin step(); n++; end
        if (beat[1] < WIN) fail("abort_feed_timeout");
        step();
        rst = 1'b1;
        active[1] = 1'b0;
        sb.delete();
        step();
        chk_zero("mid_reset");
        rst = 1'b0;
        begin
            vec_t v;
            v = '{id: 3, s: mk(20, -4, 9, 3), avg: 7, stall: 0, lat: 10};
            run_window(v);
        end
        $display("mid-WAIT reset: aborted req1, req3 avg=7");

        // All requesters busy; requester 0 re-requests right after its response.
        grant_log.delete();
        launch(0, mk(1, 1, 1, 1), 1);
        launch(1, mk(2, 2, 2, 2), 2);
        launch(2, mk(-8, -8, -8, -8), -8);
        launch(3, mk(5, 6, 7, 8), 6);
        relaunched = 0;
        n = 0;
        while ((active != 0 || !relaunched) && n < 400) begin
            if (!relaunched && !active[0]) begin
                launch(0, mk(9, 9, 9, 10), 9);
                relaunched = 1;
            end
            step();
            n++;
        end
        if (active != 0) begin fail("rr_timeout"); active = '0; end
        exp_rr = '{0, 1, 2, 3, 0};
        chk("rr_grant_count", grant_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (grant_log.size() > k) chk($sformatf("rr_grant%0d", k), grant_log[k], exp_rr[k]);
        end
        $display("round robin: %0d grants", grant_log.size());

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
